msk_tx_shaper: RTL and testbench
================================

Name: msk_tx_shaper

Overview:
Transmit-side MSK pulse shaper. It is the counterpart of the receive half-sine matched filter.
- Accepts one data bit per bit period via a valid/ready handshake.
- Steers bits alternately to I and Q arms, with Q offset by one bit period (OQPSK form of MSK).
- Shapes each bit with a half-sine pulse spanning 2 bit periods.
- Emits one signed I/Q sample pair per sample_en. Sits between the framer and the DAC/upconverter.

Parameters:
SPB, 20, samples per bit period; pulse length = 2*SPB samples; must be ≥2.
WO, 16, output sample width (signed).
AMP, 32767, pulse peak; must be ≤ 2^(WO-1)-1.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
sample_en  in  1  one output sample is produced per cycle this is high; all state frozen when low
din  in  1  data bit; 0 → +pulse, 1 → −pulse
din_val  in  1  din valid; must not depend on din_rdy
din_rdy  out  1  combinational; bit transfers when din_val && din_rdy
dout_i  out  WO  I sample, signed
dout_q  out  WO  Q sample, signed
dout_val  out  1  registered copy of sample_en
underflow  out  1  one-cycle pulse: a bit was required but din_val was low

Behaviour:
- Pulse table: h[k] = round(AMP*sin(pi*k/(2*SPB))), k = 0..2*SPB-1.
  - Constant, computed at elaboration; may be stored as a folded quarter table (k ≤ SPB, mirror for k > SPB).
  - For SPB=20: h[0]=0, h[1]=2571, h[10]=23170, h[20]=32767, h[39]=2571.
- Counters:
  - cnt runs 0..SPB-1 and advances on each sample_en in RUN.
  - phase toggles when cnt wraps SPB-1 → 0.
  - I position = phase*SPB+cnt; Q position = (1-phase)*SPB+cnt.
  - A bit boundary is sample_en && cnt==0 in RUN. At a boundary, phase=0 starts an I pulse and phase=1 starts a Q pulse.
- Per-arm state: sign bit and mute bit. A muted arm outputs 0.
  - Arm sample = mute ? 0 : (sign ? −h[pos] : +h[pos]).
  - −AMP must fit in WO bits; no saturation logic.
- States IDLE and RUN:
  - IDLE: cnt=0, phase=0, both arms muted. din_rdy = sample_en.
    - On transfer: go to RUN. The bit loads the I arm (unmuted, sign=din). This cycle computes sample 0 (I = h[0], Q = 0), and cnt becomes 1.
  - RUN: din_rdy = sample_en && cnt==0.
    - Boundary with transfer: the starting arm loads sign=din and unmutes.
    - Boundary without din_val: the starting arm mutes and underflow pulses.
    - Two consecutive missed boundaries (the other arm was muted at the previous boundary) → IDLE on that same edge. From then on all outputs are 0; the next accepted bit restarts on I with phase=0.
- Latency: the sample computed in a sample_en cycle appears on dout_i/dout_q/dout_val at the next edge (1 cycle). underflow is registered and aligned to the same edge.
- dout_i/dout_q = 0 whenever dout_val=0.
- sample_en low: no counter, state, or arm change; din_rdy=0; dout_val=0 next cycle.
- Reset (any time, including mid-pulse), effective at the next edge:
  - state=IDLE, cnt=0, phase=0, both arms muted, signs 0.
  - dout_i=dout_q=0, dout_val=0, underflow=0.
  - No partial pulse continues after reset.
- rst has priority over sample_en and din_val in the same cycle.

Test Plan:
1. Single bit: rst, sample_en=1, one transfer din=0, then din_val=0.
   - dout_i over output samples 0..39 = h[0..39] (0, 2571, …, 32767 at n=20, …, 2571); dout_q=0 throughout.
   - underflow pulses at samples 20 and 40; IDLE and all-zero output from sample 40.
2. Continuous stream 0,1,0,1,…, sample_en=1.
   - dout_i: n=20 → 32767, n=40 → 0, n=60 → 32767.
   - dout_q: n=20 → 0, n=40 → −32767.
   - din_rdy every 20 cycles; no underflow.
3. Sign check, din=1 first:
   - dout_i: n=1 → −2571, n=20 → −32767.
4. sample_en asserted every other cycle with the test 2 stream:
   - Identical sample sequence; dout_val alternates; din_rdy only in sample_en cycles.
   - dout_i/dout_q = 0 on non-valid cycles.
5. Single gap: drop din_val at one boundary mid-stream.
   - The affected arm outputs 0 for 40 samples; the other arm is unaffected.
   - One underflow pulse; the block stays in RUN.
6. Reset at output sample 10 of an I pulse:
   - Next cycle dout_val=0 and dout_i=0.
   - The next transfer restarts at h[0] on I, with Q=0 for 20 samples.

Source files
------------

// File: rtl/msk_tx_shaper.sv
// msk_tx_shaper: MSK transmit shaper, alternating I/Q half-sine pulses with Q offset by one bit period
module msk_tx_shaper #(
  parameter int SPB = 20,
  parameter int WO  = 16,
  parameter int AMP = 32767
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_en,
  input  logic                 din,
  input  logic                 din_val,
  output logic                 din_rdy,
  output logic signed [WO-1:0] dout_i,
  output logic signed [WO-1:0] dout_q,
  output logic                 dout_val,
  output logic                 underflow
);
  localparam int CW = $clog2(SPB);
  localparam int PW = $clog2(2 * SPB);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic phase, phase_n, sign_i, sign_i_n, sign_q, sign_q_n, mute_i, mute_i_n, mute_q, mute_q_n, miss;
  logic [PW-1:0] pos_i, pos_q;
  logic signed [WO-1:0] s_i, s_q;
  logic signed [WO-1:0] h [2*SPB];
  function automatic logic signed [WO-1:0] h_val(input int k);
    return WO'($rtoi(AMP * $sin(3.14159265358979 * k / (2.0 * SPB)) + 0.5));
  endfunction
  for (genvar k = 0; k < 2 * SPB; k++) begin : g_h
    assign h[k] = h_val(k);
  end
  assign din_rdy = sample_en && cnt == '0;
  assign pos_i = phase ? PW'(SPB) + PW'(cnt) : PW'(cnt);
  assign pos_q = phase ? PW'(cnt) : PW'(SPB) + PW'(cnt);
  // samples use the post-load arm state; a freshly loaded arm is at h[0]=0 anyway
  assign s_i = mute_i_n ? '0 : sign_i_n ? -h[pos_i] : h[pos_i];
  assign s_q = mute_q_n ? '0 : sign_q_n ? -h[pos_q] : h[pos_q];
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    phase_n = phase;
    sign_i_n = sign_i;
    sign_q_n = sign_q;
    mute_i_n = mute_i;
    mute_q_n = mute_q;
    miss = 1'b0;
    if (sample_en && state == IDLE && din_val) begin
      state_n = RUN;
      cnt_n = CW'(1);
      sign_i_n = din;
      mute_i_n = 1'b0;
    end else if (sample_en && state == RUN) begin
      cnt_n = (cnt == CW'(SPB - 1)) ? '0 : cnt + 1'b1;
      phase_n = (cnt == CW'(SPB - 1)) ? ~phase : phase;
      if (cnt == '0 && din_val) begin
        sign_i_n = phase ? sign_i : din;
        mute_i_n = phase ? mute_i : 1'b0;
        sign_q_n = phase ? din : sign_q;
        mute_q_n = phase ? 1'b0 : mute_q;
      end else if (cnt == '0) begin
        miss = 1'b1;
        mute_i_n = phase ? mute_i : 1'b1;
        mute_q_n = phase ? 1'b1 : mute_q;
        if (phase ? mute_i : mute_q) begin
          state_n = IDLE;
          cnt_n = '0;
          phase_n = 1'b0;
          mute_i_n = 1'b1;
          mute_q_n = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      phase <= 1'b0;
      sign_i <= 1'b0;
      sign_q <= 1'b0;
      mute_i <= 1'b1;
      mute_q <= 1'b1;
      dout_i <= '0;
      dout_q <= '0;
      dout_val <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      phase <= phase_n;
      sign_i <= sign_i_n;
      sign_q <= sign_q_n;
      mute_i <= mute_i_n;
      mute_q <= mute_q_n;
      dout_i <= sample_en ? s_i : '0;
      dout_q <= sample_en ? s_q : '0;
      dout_val <= sample_en;
      underflow <= miss;
    end
  end
endmodule

// File: tb/tb_msk_tx_shaper.sv
// tb_msk_tx_shaper: vector table, directed sequences and random stimulus against a slot-based MSK model
module tb_msk_tx_shaper;
  localparam int SPB = 20;
  localparam int WO = 16;
  logic clk = 1'b0;
  logic rst, sample_en, din, din_val, din_rdy, dout_val, underflow;
  logic signed [WO-1:0] dout_i, dout_q;
  int total = 0, bad = 0, rdy_cnt = 0, uf_cnt = 0;
  bit m_run;
  int m_t;
  bit m_sign[2], m_mute[2];
  int e_i, e_q;
  bit e_val, e_uf;
  int oi[160], oq[160];
  typedef struct {bit r, s, v, d; int ei, eq; bit ev, eu;} vec_t;
  vec_t tbl[7];

  msk_tx_shaper dut (.clk(clk), .rst(rst), .sample_en(sample_en), .din(din), .din_val(din_val),
    .din_rdy(din_rdy), .dout_i(dout_i), .dout_q(dout_q), .dout_val(dout_val), .underflow(underflow));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int hr(input int k);
    return $rtoi(32767.0 * $sin($acos(-1.0) * k / (2.0 * SPB)) + 0.5);
  endfunction

  function automatic int av(input int a, input int k);
    return m_mute[a] ? 0 : m_sign[a] ? -hr(k) : hr(k);
  endfunction

  // model: time t counts samples since the stream started; slot t/SPB alternates I,Q
  task automatic model(input bit r, input bit s, input bit v, input bit d);
    int arm;
    bit stop;
    stop = 0;
    e_uf = 0;
    e_i = 0;
    e_q = 0;
    e_val = s && !r;
    if (r) begin
      m_run = 0; m_t = 0; m_mute = '{1, 1}; m_sign = '{0, 0};
      return;
    end
    if (!s) return;
    if (!m_run) begin
      if (v) begin m_run = 1; m_t = 0; m_sign[0] = d; m_mute[0] = 0; end
    end else if (m_t % SPB == 0) begin
      arm = (m_t / SPB) % 2;
      if (v) begin m_sign[arm] = d; m_mute[arm] = 0; end
      else begin m_mute[arm] = 1; e_uf = 1; stop = m_mute[1-arm]; end
    end
    if (m_run) begin
      e_i = av(0, m_t % (2 * SPB));
      e_q = av(1, (m_t + SPB) % (2 * SPB));
    end
    if (stop) begin m_run = 0; m_mute = '{1, 1}; end
    else if (m_run) m_t++;
  endtask

  task automatic cyc(input bit r, input bit s, input bit v, input bit d);
    rst = r; sample_en = s; din_val = v; din = d;
    #1;
    if (!r) chk("din_rdy", din_rdy, (s && (!m_run || m_t % SPB == 0)));
    if (din_rdy === 1'b1) rdy_cnt++;
    @(posedge clk);
    model(r, s, v, d);
    #1;
    chk("dout_i", dout_i, e_i);
    chk("dout_q", dout_q, e_q);
    chk("dout_val", dout_val, e_val);
    chk("underflow", underflow, e_uf);
    if (underflow === 1'b1) uf_cnt++;
  endtask

  initial begin
    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 1, 1, 0, 0, 1, 0};
    tbl[2] = '{0, 1, 0, 0, -2571, 0, 1, 0};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{0, 1, 0, 0, -5126, 0, 1, 0};
    tbl[5] = '{1, 1, 1, 0, 0, 0, 0, 0};
    tbl[6] = '{0, 1, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].d);
      chk("tbl_i", dout_i, tbl[i].ei);
      chk("tbl_q", dout_q, tbl[i].eq);
      chk("tbl_val", dout_val, tbl[i].ev);
      chk("tbl_uf", underflow, tbl[i].eu);
    end
    // single bit, then starvation back to idle
    cyc(1, 0, 0, 0);
    uf_cnt = 0;
    for (int n = 0; n < 45; n++) begin
      cyc(0, 1, n == 0, 0);
      oi[n] = dout_i; oq[n] = dout_q;
      if (n == 20 || n == 40) chk("t1_uf_pulse", underflow, 1);
    end
    chk("t1_h1", oi[1], 2571);
    chk("t1_h10", oi[10], 23170);
    chk("t1_h20", oi[20], 32767);
    chk("t1_h39", oi[39], 2571);
    chk("t1_q", oq[30], 0);
    chk("t1_idle", oi[41], 0);
    chk("t1_uf_cnt", uf_cnt, 2);
    // continuous alternating stream
    cyc(1, 0, 0, 0);
    uf_cnt = 0; rdy_cnt = 0;
    for (int n = 0; n < 70; n++) begin
      cyc(0, 1, 1, (n / SPB) % 2);
      oi[n] = dout_i; oq[n] = dout_q;
    end
    chk("t2_i20", oi[20], 32767);
    chk("t2_i40", oi[40], 0);
    chk("t2_i60", oi[60], 32767);
    chk("t2_q20", oq[20], 0);
    chk("t2_q40", oq[40], -32767);
    chk("t2_rdy", rdy_cnt, 4);
    chk("t2_uf", uf_cnt, 0);
    // same stream at half sample rate
    cyc(1, 0, 0, 0);
    rdy_cnt = 0;
    for (int c = 0; c < 140; c++) begin
      cyc(0, c % 2 == 0, 1, (c / (2 * SPB)) % 2);
      if (c == 80) chk("t4_q40", dout_q, -32767);
    end
    chk("t4_rdy", rdy_cnt, 4);
    // one missed Q boundary mid-stream
    cyc(1, 0, 0, 0);
    uf_cnt = 0;
    for (int n = 0; n < 120; n++) begin
      cyc(0, 1, n != 60, (n / SPB) % 2);
      oi[n] = dout_i; oq[n] = dout_q;
    end
    chk("t5_uf", uf_cnt, 1);
    chk("t5_q70", oq[70], 0);
    chk("t5_i70", oi[70], hr(30));
    chk("t5_i100", oi[100], 32767);
    // reset in the middle of an I pulse
    cyc(1, 0, 0, 0);
    for (int n = 0; n < 11; n++) cyc(0, 1, n == 0, 0);
    chk("t6_pre", dout_i, 32767 == 32767 ? hr(10) : 0);
    cyc(1, 1, 0, 0);
    chk("t6_val", dout_val, 0);
    chk("t6_i", dout_i, 0);
    cyc(0, 1, 1, 0);
    chk("t6_h0", dout_i, 0);
    for (int n = 1; n < 21; n++) begin
      cyc(0, 1, 0, 0);
      if (n == 1) chk("t6_h1", dout_i, 2571);
      chk("t6_q", dout_q, 0);
    end
    // random traffic
    cyc(1, 0, 0, 0);
    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(999) < 3, $urandom_range(3) != 0, $urandom_range(9) != 0, 1'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
